// File: rtl/quantum_sched_pkg.sv
// quantum_sched_pkg: shared state encoding and default widths for the quantum scheduler
package quantum_sched_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REQ  = 2'd2
    } state_t;
    localparam int NUM_PROC_DEF  = 4;
    localparam int QUANTUM_W_DEF = 8;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick of the first set mask bit at or after i_start, wrapping
//   i_mask  - candidate bit per slot
//   i_start - first slot searched; i_start-1 is searched last
//   o_found - some bit of i_mask is set
//   o_pid   - selected slot (i_start when nothing is found)
module rr_picker
    import quantum_sched_pkg::*;
#(
    parameter int  NUM_PROC = NUM_PROC_DEF,
    localparam int PID_W    = $clog2(NUM_PROC)
) (
    input  logic [NUM_PROC-1:0] i_mask,
    input  logic [PID_W-1:0]    i_start,
    output logic                o_found,
    output logic [PID_W-1:0]    o_pid
);
    // Scanning the rotated offsets downwards leaves the lowest offset as the final winner.
    always_comb begin
        o_found = 1'b0;
        o_pid   = i_start;
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            if (i_mask[i_start + PID_W'(k)]) begin
                o_found = 1'b1;
                o_pid   = i_start + PID_W'(k);
            end
        end
    end
endmodule

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: preemptive round-robin scheduler with instruction quantum and switch handshake
//   i_clock / i_reset          - rising-edge clock, asynchronous active-low reset
//   i_enable                   - 0 freezes the counter and blocks new switch requests
//   i_quantum                  - instructions per slice (0 behaves as 1)
//   i_instr_retire / i_halt    - pulses from the running process
//   i_load_valid / i_load_pid  - mark a slot ready after loading
//   i_switch_ack               - control path finished the context switch
//   o_switch_req / o_next_pid  - pending switch and its target (stable while requested)
//   o_cur_pid / o_ready_mask   - running slot and ready bits
//   o_idle                     - no runnable process
module quantum_scheduler
    import quantum_sched_pkg::*;
#(
    parameter int  NUM_PROC  = NUM_PROC_DEF,
    parameter int  QUANTUM_W = QUANTUM_W_DEF,
    localparam int PID_W     = $clog2(NUM_PROC)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [QUANTUM_W-1:0] i_quantum,
    input  logic                 i_instr_retire,
    input  logic                 i_halt,
    input  logic                 i_load_valid,
    input  logic [PID_W-1:0]     i_load_pid,
    input  logic                 i_switch_ack,
    output logic                 o_switch_req,
    output logic [PID_W-1:0]     o_next_pid,
    output logic [PID_W-1:0]     o_cur_pid,
    output logic [NUM_PROC-1:0]  o_ready_mask,
    output logic                 o_idle
);
    state_t               r_state, w_state_nxt;
    logic [PID_W-1:0]     r_cur_pid, r_next_pid, w_cur_nxt, w_next_nxt, w_pick_pid;
    logic [NUM_PROC-1:0]  r_ready, w_ready_nxt, w_pick_mask, w_halt_bit, w_load_bit;
    logic [QUANTUM_W-1:0] r_cnt, w_cnt_nxt, w_qlast;
    logic                 w_halt, w_retire, w_expire, w_found;

    // Retire and halt only matter while a process runs with the scheduler enabled.
    assign w_halt      = (r_state == RUN) && i_enable && i_halt;
    assign w_retire    = (r_state == RUN) && i_enable && i_instr_retire;
    assign w_qlast     = i_quantum - QUANTUM_W'(i_quantum != '0);
    // >= so that shrinking the quantum mid-slice expires on the next retire.
    assign w_expire    = w_retire && (r_cnt >= w_qlast);
    assign w_halt_bit  = w_halt ? NUM_PROC'(1) << r_cur_pid : '0;
    assign w_load_bit  = i_load_valid ? NUM_PROC'(1) << i_load_pid : '0;
    // Load is applied after the halt clear so a coincident load keeps the slot ready.
    assign w_ready_nxt = (r_ready & ~w_halt_bit) | w_load_bit;
    // A halted process is excluded from the search; the current slot is otherwise searched last.
    assign w_pick_mask = r_ready & ~w_halt_bit;

    rr_picker #(.NUM_PROC(NUM_PROC)) u_picker (
        .i_mask  (w_pick_mask),
        .i_start (r_cur_pid + PID_W'(1)),
        .o_found (w_found),
        .o_pid   (w_pick_pid)
    );

    always_comb begin
        w_state_nxt = (r_state == RUN || r_state == REQ) ? r_state : IDLE;
        w_cur_nxt   = r_cur_pid;
        w_next_nxt  = r_next_pid;
        w_cnt_nxt   = (w_retire && r_cnt != '1) ? r_cnt + QUANTUM_W'(1) : r_cnt;
        if (r_state == IDLE && i_enable && r_ready != '0) begin
            w_next_nxt  = w_pick_pid;
            w_state_nxt = REQ;
        end else if (w_halt || w_expire) begin
            if (!w_found) begin
                w_state_nxt = IDLE;
            end else if (w_pick_pid == r_cur_pid) begin
                w_cnt_nxt = '0;
            end else begin
                w_next_nxt  = w_pick_pid;
                w_state_nxt = REQ;
            end
        end else if (r_state == REQ && i_switch_ack) begin
            w_cur_nxt   = r_next_pid;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_cur_pid  <= '0;
            r_next_pid <= '0;
            r_ready    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_pid  <= w_cur_nxt;
            r_next_pid <= w_next_nxt;
            r_ready    <= w_ready_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign o_switch_req = (r_state == REQ);
    assign o_idle       = (r_state == IDLE);
    assign o_next_pid   = r_next_pid;
    assign o_cur_pid    = r_cur_pid;
    assign o_ready_mask = r_ready;
endmodule

// File: tb/tb_quantum_scheduler.sv
// tb_quantum_scheduler: directed scenarios plus random traffic checked against a behavioural model
module tb_quantum_scheduler;
    localparam int NP = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n, en, ret, hlt, lv, ack;
    logic [PW-1:0] lpid;
    logic [7:0]    q;
    logic          sreq, idl;
    logic [PW-1:0] npid, cpid;
    logic [NP-1:0] rmask;

    always #5 clk = ~clk;

    quantum_scheduler #(.NUM_PROC(NP), .QUANTUM_W(8)) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_enable       (en),
        .i_quantum      (q),
        .i_instr_retire (ret),
        .i_halt         (hlt),
        .i_load_valid   (lv),
        .i_load_pid     (lpid),
        .i_switch_ack   (ack),
        .o_switch_req   (sreq),
        .o_next_pid     (npid),
        .o_cur_pid      (cpid),
        .o_ready_mask   (rmask),
        .o_idle         (idl)
    );

    int n_chk = 0;
    int n_pass = 0;

    bit m_ready[NP];
    bit m_idle, m_pend;
    int m_cur, m_next, m_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int mask_val();
        int v = 0;
        for (int k = 0; k < NP; k++) if (m_ready[k]) v += (1 << k);
        return v;
    endfunction

    // First ready slot after 'from' in wrapping order, 'from' itself last; -1 if none.
    function automatic int pick(input bit msk[NP], input int from);
        for (int k = 1; k <= NP; k++) if (msk[(from + k) % NP]) return (from + k) % NP;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) m_ready[k] = 0;
        m_idle = 1; m_pend = 0; m_cur = 0; m_next = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit nr[NP];
        bit sel[NP];
        bit expire;
        int c, ql;
        nr = m_ready;
        if (m_idle) begin
            if (en && mask_val() != 0) begin
                m_next = pick(m_ready, m_cur);
                m_pend = 1;
                m_idle = 0;
            end
        end else if (m_pend) begin
            if (ack) begin
                m_cur = m_next;
                m_cnt = 0;
                m_pend = 0;
            end
        end else if (en) begin
            ql = (q == 0) ? 0 : int'(q) - 1;
            expire = ret && (m_cnt >= ql);
            if (ret && m_cnt < 255) m_cnt++;
            sel = m_ready;
            if (hlt) begin
                sel[m_cur] = 0;
                nr[m_cur] = 0;
            end
            if (hlt || expire) begin
                c = pick(sel, m_cur);
                if (c < 0) m_idle = 1;
                else if (c == m_cur) m_cnt = 0;
                else begin
                    m_next = c;
                    m_pend = 1;
                end
            end
        end
        if (lv) nr[lpid] = 1;
        m_ready = nr;
    endtask

    task automatic check_all();
        chk("switch_req", int'(sreq), int'(m_pend));
        chk("idle", int'(idl), int'(m_idle));
        chk("cur_pid", int'(cpid), m_cur);
        chk("next_pid", int'(npid), m_next);
        chk("ready_mask", int'(rmask), mask_val());
    endtask

    task automatic cyc(input bit e, input bit r, input bit h, input bit l, input int p, input bit a);
        en = e; ret = r; hlt = h; lv = l; lpid = PW'(p); ack = a;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 0; ret = 0; hlt = 0; lv = 0; lpid = '0; ack = 0; q = 8'd4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_idle", int'(idl), 1);
        rst_n = 1'b1;

        // load slot 2: visible in the mask first, requested one cycle later
        cyc(1, 0, 0, 1, 2, 0);
        chk("s1_idle_until_mask", int'(idl), 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("s1_req", int'(sreq), 1);
        chk("s1_next", int'(npid), 2);
        cyc(1, 0, 0, 0, 0, 1);
        chk("s1_cur", int'(cpid), 2);
        chk("s1_run", int'(idl), 0);

        // get slot 0 running with 0 and 1 ready, then quantum 3
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("s2_halt_next", int'(npid), 0);
        cyc(1, 0, 0, 0, 0, 1);
        q = 8'd3;
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s2_no_req_early", int'(sreq), 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s2_req_expiry", int'(sreq), 1);
        chk("s2_next", int'(npid), 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("s2_cur", int'(cpid), 1);

        // make slot 1 the sole ready process, quantum 2
        q = 8'd2;
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("s3_sole_mask", int'(rmask), 2);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            chk("s3_no_req", int'(sreq), 0);
        end
        // slice was reloaded: one retire after loading 3 must not yet switch
        cyc(1, 0, 0, 1, 3, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s3_reload", int'(sreq), 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s3_switch", int'(sreq), 1);
        chk("s3_next", int'(npid), 3);
        cyc(1, 0, 0, 0, 0, 1);

        // 0,1,3 ready running 3, halt chain down to idle
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("s4_mask", int'(rmask), 3);
        chk("s4_wrap", int'(npid), 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 0);
        chk("s4_idle", int'(idl), 1);
        chk("s4_noreq", int'(sreq), 0);

        // quantum 0: every retire expires; halt with retire behaves as halt
        q = 8'd0;
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 2, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s5_q0_next", int'(npid), 2);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0);
        chk("s5_halt_wins_mask", int'(rmask), 1);
        chk("s5_next", int'(npid), 0);

        // disable while requested, late ack still completes
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("s6_held", int'(sreq), 1);
            chk("s6_stable", int'(npid), 0);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("s6_cur", int'(cpid), 0);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s6_req_again", int'(sreq), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_req", int'(sreq), 0);
        chk("s6_async_mask", int'(rmask), 0);
        chk("s6_async_idle", int'(idl), 1);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) q = 8'($urandom_range(0, 4));
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                $urandom_range(0, 5) == 0, int'($urandom_range(0, NP - 1)), $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
